bc_msg_broadcaster: RTL and testbench

// - Central broadcast-message hub between the RISC-V core wrappers.
// - Collects each core's bc_msg_out ready/valid stream through a round-robin arbiter.
// - Re-broadcasts the winning message to every core's bc_msg_in. That input is valid-only with no backpressure.
// - Sits directly downstream of every core's bc_msg_out port and upstream of every core's bc_msg_in port.

---
 rtl/bc_pkg.sv | 30 +++
 rtl/bc_msg_broadcaster_rr_arbiter.sv | 67 ++++++
 rtl/bc_msg_broadcaster.sv | 112 +++++++++++
 tb/tb_bc_msg_broadcaster.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the broadcast-message hub and its neighbours.
//   MSG_WIDTH_DEF      : default broadcast message width (matches core wrappers)
//   BC_REGION_SIZE_DEF : size of the broadcast address region
//   bc_split_msg()     : splits an opaque message into addr / data / strobe
//                        fields. The hub itself never looks inside a message;
//                        the split exists so that observers can decode traffic.
// ---------------------------------------------------------------------------
package bc_pkg;

    localparam int MSG_WIDTH_DEF      = 47;
    localparam int BC_REGION_SIZE_DEF = 8192;

    localparam int BC_DATA_WIDTH = 32;
    localparam int BC_STRB_WIDTH = 4;
    localparam int BC_ADDR_WIDTH = MSG_WIDTH_DEF - BC_DATA_WIDTH - BC_STRB_WIDTH;

    // Packed MSB-first, so the address lands in the low bits of the message.
    typedef struct packed {
        logic [BC_STRB_WIDTH-1:0] strb;
        logic [BC_DATA_WIDTH-1:0] data;
        logic [BC_ADDR_WIDTH-1:0] addr;
    } bc_msg_fields_t;

    function automatic bc_msg_fields_t bc_split_msg(input logic [MSG_WIDTH_DEF-1:0] msg);
        return bc_msg_fields_t'(msg);
    endfunction

endpackage

// File: rtl/bc_msg_broadcaster_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter that owns the last_grant pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-port request vector
//   update_en  : when high and a grant exists, the pointer moves to the winner
//   grant      : one-hot grant (all-zero when req is zero), combinational
//   grant_idx  : index of the granted port (0 when no grant)
// Search starts at last_grant+1 and wraps modulo PORTS. The wrap is done with
// an explicit compare/subtract so non-power-of-two port counts work.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int PORTS = 16,
    parameter int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req,
    input  logic             update_en,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant_r;
    logic [PORTS-1:0] grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             found_s;
    logic [IDX_W:0]   cand_s;

    // Rotating priority search: first requester after the last winner.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        cand_s      = '0;
        for (int off = 1; off <= PORTS; off++) begin
            cand_s = {1'b0, last_grant_r} + (IDX_W+1)'(off);
            if (cand_s >= (IDX_W+1)'(PORTS)) begin
                cand_s = cand_s - (IDX_W+1)'(PORTS);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                found_s                     = 1'b1;
                grant_s[cand_s[IDX_W-1:0]]  = 1'b1;
                grant_idx_s                 = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register; reset value makes port 0 the first to be searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= IDX_W'(PORTS - 1);
        end else if (update_en && found_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;

endmodule

// File: rtl/bc_msg_broadcaster.sv
// ---------------------------------------------------------------------------
// bc_msg_broadcaster
// Central broadcast hub: arbitrates the cores' bc_msg_out ready/valid streams
// round-robin and re-broadcasts the winner on the valid-only bc_msg_in bus.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bc_msg_out        : per-core messages, core i at [i*MSG_WIDTH +: MSG_WIDTH]
//   bc_msg_out_valid  : per-core valid
//   bc_msg_out_ready  : per-core ready, one-hot or zero (combinational grant)
//   core_enable       : per-core grant mask
//   bc_stall          : suspends all grants in the same cycle
//   bc_msg_in         : registered broadcast message
//   bc_msg_in_valid   : single-cycle pulse per broadcast message
//   bc_msg_src        : index of the core that sourced bc_msg_in
//   bc_msg_count      : saturating count of broadcast messages since reset
// ---------------------------------------------------------------------------
module bc_msg_broadcaster
    import bc_pkg::*;
#(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = MSG_WIDTH_DEF,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] bc_msg_out,
    input  logic [CORE_COUNT-1:0]           bc_msg_out_valid,
    output logic [CORE_COUNT-1:0]           bc_msg_out_ready,
    input  logic [CORE_COUNT-1:0]           core_enable,
    input  logic                            bc_stall,
    output logic [MSG_WIDTH-1:0]            bc_msg_in,
    output logic                            bc_msg_in_valid,
    output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
    output logic [CNT_WIDTH-1:0]            bc_msg_count
);

    logic [CORE_COUNT-1:0]    req_s;
    logic [CORE_COUNT-1:0]    grant_s;
    logic [CORE_ID_WIDTH-1:0] grant_idx_s;
    logic                     grant_any_s;
    logic [MSG_WIDTH-1:0]     msg_mux_s;

    logic [MSG_WIDTH-1:0]     bc_msg_in_r;
    logic                     bc_msg_in_valid_r;
    logic [CORE_ID_WIDTH-1:0] bc_msg_src_r;
    logic [CNT_WIDTH-1:0]     bc_msg_count_r;

    // Gating with rst_n keeps ready low for the whole time reset is asserted,
    // so no core believes a handshake completed while the hub is in reset.
    assign req_s       = bc_msg_out_valid & core_enable
                       & {CORE_COUNT{~bc_stall}} & {CORE_COUNT{rst_n}};
    assign grant_any_s = |grant_s;

    rr_arbiter #(
        .PORTS (CORE_COUNT),
        .IDX_W (CORE_ID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_s),
        .update_en (grant_any_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // One-hot AND-OR mux selecting the granted core's message.
    always_comb begin
        msg_mux_s = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant_s[i]) begin
                msg_mux_s = bc_msg_out[i*MSG_WIDTH +: MSG_WIDTH];
            end else begin
                msg_mux_s = msg_mux_s;
            end
        end
    end

    // Broadcast output register: capture the winner, otherwise pulse ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_msg_in_r       <= '0;
            bc_msg_in_valid_r <= 1'b0;
            bc_msg_src_r      <= '0;
        end else if (grant_any_s) begin
            bc_msg_in_r       <= msg_mux_s;
            bc_msg_in_valid_r <= 1'b1;
            bc_msg_src_r      <= grant_idx_s;
        end else begin
            bc_msg_in_r       <= bc_msg_in_r;
            bc_msg_in_valid_r <= 1'b0;
            bc_msg_src_r      <= bc_msg_src_r;
        end
    end

    // Saturating statistics counter of broadcast pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_msg_count_r <= '0;
        end else if (bc_msg_in_valid_r && (bc_msg_count_r != {CNT_WIDTH{1'b1}})) begin
            bc_msg_count_r <= bc_msg_count_r + CNT_WIDTH'(1);
        end else begin
            bc_msg_count_r <= bc_msg_count_r;
        end
    end

    assign bc_msg_out_ready = grant_s;
    assign bc_msg_in        = bc_msg_in_r;
    assign bc_msg_in_valid  = bc_msg_in_valid_r;
    assign bc_msg_src       = bc_msg_src_r;
    assign bc_msg_count     = bc_msg_count_r;

endmodule

// File: tb/tb_bc_msg_broadcaster.sv
// ---------------------------------------------------------------------------
// tb_bc_msg_broadcaster
// Self-checking bench for bc_msg_broadcaster. A 32-bit-counter instance and a
// 4-bit-counter instance share all inputs. Expected values come from a
// behavioural model: pointer as an integer, modulo search, saturating counts.
// ---------------------------------------------------------------------------
module tb_bc_msg_broadcaster;

    localparam int CC = 16;
    localparam int MW = 47;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CC*MW-1:0] bc_msg_out;
    logic [CC-1:0]    valid;
    logic [CC-1:0]    enable;
    logic             stall;

    logic [CC-1:0]    ready,  ready4;
    logic [MW-1:0]    msg_in, msg_in4;
    logic             vld,    vld4;
    logic [3:0]       src,    src4;
    logic [31:0]      count;
    logic [3:0]       count4;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int            m_lg;
    logic          m_valid;
    logic [MW-1:0] m_msg;
    logic [3:0]    m_src;
    logic [63:0]   m_cnt;
    logic [63:0]   m_cnt4;

    always #5 clk = ~clk;

    bc_msg_broadcaster #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bc_msg_out(bc_msg_out), .bc_msg_out_valid(valid),
        .bc_msg_out_ready(ready), .core_enable(enable), .bc_stall(stall),
        .bc_msg_in(msg_in), .bc_msg_in_valid(vld), .bc_msg_src(src), .bc_msg_count(count)
    );

    bc_msg_broadcaster #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bc_msg_out(bc_msg_out), .bc_msg_out_valid(valid),
        .bc_msg_out_ready(ready4), .core_enable(enable), .bc_stall(stall),
        .bc_msg_in(msg_in4), .bc_msg_in_valid(vld4), .bc_msg_src(src4), .bc_msg_count(count4)
    );

    function automatic void model_reset();
        m_lg    = CC - 1;
        m_valid = 1'b0;
        m_msg   = '0;
        m_src   = 4'd0;
        m_cnt   = 64'd0;
        m_cnt4  = 64'd0;
    endfunction

    // Winner under the current inputs, or -1 when nobody may be granted.
    function automatic int model_grant();
        int idx;
        if (stall) return -1;
        for (int k = 1; k <= CC; k++) begin
            idx = (m_lg + k) % CC;
            if (valid[idx] && enable[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [CC-1:0] exp_ready();
        logic [CC-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [MW+36:0] exp_out();
        return {m_valid, m_src, m_msg, m_cnt[31:0]};
    endfunction

    // Advance one clock; model follows the edge. Ends 1 time unit after it.
    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (m_valid) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 64'd1;
            if (m_cnt4 < 64'd15)       m_cnt4 = m_cnt4 + 64'd1;
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_msg   = bc_msg_out[g*MW +: MW];
            m_src   = 4'(g);
            m_lg    = g;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_msgs();
        for (int c = 0; c < CC; c++) begin
            bc_msg_out[c*MW +: MW] = MW'({$urandom(), $urandom()});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '1; enable = '1; stall = 1'b0;
        rand_msgs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ready !== 16'h0000) begin n_err++; $display("FAIL reset_ready: got %h expected 0000", ready); end
        n_vec++; if ({vld, src, msg_in} !== 52'd0) begin n_err++; $display("FAIL reset_outputs: valid=%b src=%0d msg=%h expected all zero", vld, src, msg_in); end
        n_vec++; if (count !== 32'd0 || count4 !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d/%0d expected 0", count, count4); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (ready !== 16'h0001) begin n_err++; $display("FAIL reset_first_grant: got %h expected 0001", ready); end
        tick();
        n_vec++; if (vld !== 1'b1 || src !== 4'd0 || msg_in !== bc_msg_out[0 +: MW]) begin
            n_err++; $display("FAIL reset_first_msg: valid=%b src=%0d msg=%h expected 1/0/%h", vld, src, msg_in, bc_msg_out[0 +: MW]);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        valid = 16'h0020; enable = '1; stall = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bc_msg_out = '0;
            bc_msg_out[5*MW +: MW] = MW'(k);
            #1;
            n_vec++; if (ready !== 16'h0020) begin n_err++; $display("FAIL single_ready[%0d]: got %h expected 0020", k, ready); end
            tick();
            n_vec++; if (vld !== 1'b1 || src !== 4'd5 || msg_in !== MW'(k)) begin
                n_err++; $display("FAIL single_msg[%0d]: valid=%b src=%0d msg=%h expected 1/5/%h", k, vld, src, msg_in, k);
            end
        end
        valid = '0;
        #1;
        n_vec++; if (ready !== 16'h0000) begin n_err++; $display("FAIL single_idle_ready: got %h expected 0000", ready); end
        tick();
        n_vec++; if (vld !== 1'b0 || msg_in !== MW'(8) || count !== 32'd8) begin
            n_err++; $display("FAIL single_end: valid=%b msg=%h count=%0d expected 0/8/8", vld, msg_in, count);
        end
    endtask

    task automatic test_contention();
        logic [CC-1:0] e;
        do_reset();
        valid = '1; enable = '1; stall = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rand_msgs();
            e = '0; e[i % CC] = 1'b1;
            #1;
            n_vec++; if (ready !== e) begin n_err++; $display("FAIL contend_ready[%0d]: got %h expected %h", i, ready, e); end
            tick();
            n_vec++; if (src !== 4'(i % CC) || {vld, src, msg_in, count} !== exp_out()) begin
                n_err++; $display("FAIL contend_out[%0d]: got %h expected %h (src %0d)", i, {vld, src, msg_in, count}, exp_out(), i % CC);
            end
        end
        valid = '0;
        #1;
        tick();
        n_vec++; if (count !== 32'd32) begin n_err++; $display("FAIL contend_count: got %0d expected 32", count); end
    endtask

    task automatic test_mask_stall();
        int order [4] = '{2, 4, 2, 4};
        logic [CC-1:0] e;
        do_reset();
        enable = '1; enable[3] = 1'b0;
        valid = 16'h001C; stall = 1'b0;
        rand_msgs();
        for (int i = 0; i < 4; i++) begin
            e = '0; e[order[i]] = 1'b1;
            #1;
            n_vec++; if (ready !== e) begin n_err++; $display("FAIL mask_ready[%0d]: got %h expected %h", i, ready, e); end
            tick();
            n_vec++; if (src !== 4'(order[i]) || vld !== 1'b1) begin
                n_err++; $display("FAIL mask_src[%0d]: got %0d/%b expected %0d/1", i, src, vld, order[i]);
            end
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ready !== 16'h0000) begin n_err++; $display("FAIL stall_ready[%0d]: got %h expected 0000", i, ready); end
            tick();
            n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, vld); end
        end
        stall = 1'b0;
        #1;
        n_vec++; if (ready !== 16'h0004) begin n_err++; $display("FAIL stall_resume_ready: got %h expected 0004", ready); end
        tick();
        n_vec++; if ({vld, src, msg_in, count} !== exp_out() || src !== 4'd2) begin
            n_err++; $display("FAIL stall_resume_out: got %h expected %h", {vld, src, msg_in, count}, exp_out());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            valid  = CC'($urandom());
            enable = CC'($urandom()) | CC'($urandom());
            stall  = ($urandom_range(0, 7) == 0);
            rand_msgs();
            #1;
            n_vec++; if (ready !== exp_ready() || ready4 !== exp_ready()) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %h/%h expected %h", i, ready, ready4, exp_ready());
            end
            tick();
            n_vec++; if ({vld, src, msg_in, count} !== exp_out() || {vld4, src4, msg_in4, count4} !== {m_valid, m_src, m_msg, m_cnt4[3:0]}) begin
                n_err++; $display("FAIL rand_out[%0d]: got %h expected %h (cnt4 %0d vs %0d)", i, {vld, src, msg_in, count}, exp_out(), count4, m_cnt4);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        valid = '0; valid[9] = 1'b1; enable = '1; stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_msgs();
            #1;
            tick();
            n_vec++; if (count4 !== m_cnt4[3:0]) begin n_err++; $display("FAIL sat_step[%0d]: got %0d expected %0d", i, count4, m_cnt4); end
        end
        valid = '0;
        #1;
        tick();
        n_vec++; if (count4 !== 4'd15 || count !== 32'd20) begin
            n_err++; $display("FAIL sat_final: got %0d/%0d expected 15/20", count4, count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        valid = '1; enable = '1; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_msgs();
            #1;
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ready !== 16'h0000 || vld !== 1'b0) begin n_err++; $display("FAIL async_rst_ctrl: ready=%h valid=%b expected 0000/0", ready, vld); end
        n_vec++; if (count !== 32'd0 || msg_in !== '0 || src !== 4'd0) begin
            n_err++; $display("FAIL async_rst_data: count=%0d msg=%h src=%0d expected zeros", count, msg_in, src);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_vec++; if (ready !== 16'h0001) begin n_err++; $display("FAIL async_rst_regrant: got %h expected 0001", ready); end
        tick();
        n_vec++; if ({vld, src, msg_in, count} !== exp_out()) begin
            n_err++; $display("FAIL async_rst_out: got %h expected %h", {vld, src, msg_in, count}, exp_out());
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = '0; enable = '0; stall = 1'b0; bc_msg_out = '0;
        #2;
        test_reset();
        test_single_source();
        test_contention();
        test_mask_stall();
        test_random();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
